// File: rtl/osd_pkg.sv
// OSD SPI link command encoding, op codes and line geometry shared by the
// transmit master and anything that issues OSD commands.
package osd_pkg;

  localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
  localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
  localparam int         OSD_LINE_BYTES = 256;

  typedef enum logic [1:0] {
    OSD_OP_DISABLE = 2'd0,
    OSD_OP_ENABLE  = 2'd1,
    OSD_OP_WRITE   = 2'd2
  } osd_op_e;

  // Op code 3 has no enum member; it is accepted and silently dropped.
  localparam logic [1:0] OSD_OP_RESERVED = 2'd3;

  // Disable shares the enable opcode with bit 0 clear.
  function automatic logic [7:0] osd_cmd_byte(input logic [1:0] op, input logic [2:0] line);
    logic [7:0] cmd;
    cmd = OSD_CMD_ENABLE;
    if (op == OSD_OP_WRITE) begin
      cmd = OSD_CMD_WRITE | {5'd0, line};
    end else if (op == OSD_OP_ENABLE) begin
      cmd = OSD_CMD_ENABLE | 8'h01;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/spi_bit_shifter.sv
// Shifts one byte MSB first onto SCK/DI: CLK_DIV cycles low, then CLK_DIV
// cycles high per bit. A load starts a byte; byte_done pulses on its last cycle.
module spi_bit_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       byte_done,
  output logic       sck,
  output logic       di
);

  localparam logic [1:0] SH_IDLE = 2'd0;
  localparam logic [1:0] SH_LOW  = 2'd1;
  localparam logic [1:0] SH_HIGH = 2'd2;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       phase_end;

  assign phase_end = (div_q == DIV_LAST);

  // A load always wins so a new byte can start on the same edge a phase ends.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    byte_done = 1'b0;
    case (state_q)
      SH_LOW: begin
        if (phase_end) begin
          state_d = SH_HIGH;
          div_d   = 8'd0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SH_HIGH: begin
        if (phase_end) begin
          div_d = 8'd0;
          if (bit_q != 3'd7) begin
            state_d = SH_LOW;
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
          end else begin
            state_d   = SH_IDLE;
            byte_done = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
      end
    endcase
    if (load) begin
      state_d = SH_LOW;
      div_d   = 8'd0;
      shift_d = load_byte;
      bit_d   = 3'd0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SH_IDLE;
      div_q   <= 8'd0;
      shift_q <= 8'd0;
      bit_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  assign sck = (state_q == SH_HIGH);
  assign di  = shift_q[7];

endmodule

// File: rtl/osd_spi_master.sv
// Transmit side of the OSD SPI link: frames a command byte (plus 256 fetched
// payload bytes for a line write) with SPI_SS3 and paces the inter-command gap.
module osd_spi_master
  import osd_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int LINE_BYTES = OSD_LINE_BYTES
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_line,
  output logic       data_req,
  output logic [7:0] data_addr,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DI
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ACCEPT    = 3'd1;
  localparam logic [2:0] ST_SHIFT     = 3'd2;
  localparam logic [2:0] ST_FETCH_REQ = 3'd3;
  localparam logic [2:0] ST_FETCH_CAP = 3'd4;
  localparam logic [2:0] ST_TAIL      = 3'd5;
  localparam logic [2:0] ST_GAP       = 3'd6;

  localparam logic [8:0] TAIL_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] LINE_LEN  = 9'(LINE_BYTES);

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] line_q, line_d;
  logic [8:0] byte_cnt_q, byte_cnt_d;
  logic [8:0] wait_q, wait_d;

  logic       sh_load;
  logic [7:0] sh_byte;
  logic       sh_done;
  logic       sh_sck;
  logic       sh_di;
  logic       ss_active;

  spi_bit_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .load      (sh_load),
    .load_byte (sh_byte),
    .byte_done (sh_done),
    .sck       (sh_sck),
    .di        (sh_di)
  );

  // The ACCEPT cycle gives every command, reserved ones included, a one-cycle
  // ready drop and lets SS3 fall on the edge after the handshake.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    line_d     = line_q;
    byte_cnt_d = byte_cnt_q;
    wait_d     = wait_q;
    sh_load    = 1'b0;
    sh_byte    = osd_cmd_byte(op_q, line_q);
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          line_d     = cmd_line;
          byte_cnt_d = 9'd0;
          state_d    = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (op_q == OSD_OP_RESERVED) begin
          state_d = ST_IDLE;
        end else begin
          sh_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          if ((op_q == OSD_OP_WRITE) && (byte_cnt_q < LINE_LEN)) begin
            state_d = ST_FETCH_REQ;
          end else begin
            state_d = ST_TAIL;
            wait_d  = 9'd0;
          end
        end
      end
      ST_FETCH_REQ: begin
        state_d = ST_FETCH_CAP;
      end
      ST_FETCH_CAP: begin
        sh_load    = 1'b1;
        sh_byte    = data_in;
        byte_cnt_d = byte_cnt_q + 9'd1;
        state_d    = ST_SHIFT;
      end
      ST_TAIL: begin
        if (wait_q == TAIL_LAST) begin
          wait_d  = 9'd0;
          state_d = ST_GAP;
        end else begin
          wait_d = wait_q + 9'd1;
        end
      end
      ST_GAP: begin
        if (wait_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 9'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'd0;
      line_q     <= 3'd0;
      byte_cnt_q <= 9'd0;
      wait_q     <= 9'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      line_q     <= line_d;
      byte_cnt_q <= byte_cnt_d;
      wait_q     <= wait_d;
    end
  end

  // Pins decode straight from reset flops, so reset parks the bus immediately.
  assign ss_active = (state_q == ST_SHIFT) || (state_q == ST_FETCH_REQ) ||
                     (state_q == ST_FETCH_CAP) || (state_q == ST_TAIL);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign data_req  = (state_q == ST_FETCH_REQ);
  assign data_addr = byte_cnt_q[7:0];
  assign SPI_SS3   = ~ss_active;
  assign SPI_SCK   = sh_sck & ss_active;
  assign SPI_DI    = sh_di & ss_active;

endmodule

// File: doc/osd_spi_master.md
# osd_spi_master

Transmit side of the OSD SPI link. Serialises OSD commands onto `SPI_SCK`/`SPI_SS3`/`SPI_DI`:
- enable/disable, as one byte;
- line write, as one command byte plus 256 payload bytes fetched from a caller-owned line buffer.

It sits in the io-controller/test-harness side of the design and drives the OSD overlay's SPI pins directly. It runs entirely in the `clk_sys` domain.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk_sys` cycles per SCK half-period. Legal range is 1..255.
- `LINE_BYTES`, default 256: payload bytes per line write. This is fixed by the OSD buffer layout; only 256 is legal.

Ports:
- `clk_sys`  in  1  system clock. Everything is synchronous to its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE. A command is accepted on `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  0 = disable, 1 = enable, 2 = write line, 3 = reserved.
- `cmd_line`  in  3  line number for write.
- `data_req`  out  1  one-cycle fetch strobe.
- `data_addr`  out  8  byte index within the line, 0..255.
- `data_in`  in  8  payload byte. Valid the cycle after `data_req`.
- `busy`  out  1  transaction or gap in progress. Always `~cmd_ready`.
- `SPI_SCK`  out  1  serial clock. Idles low.
- `SPI_SS3`  out  1  chip select, active-low. Idles high.
- `SPI_DI`  out  1  serial data, MSB first.

## Operation
Protocol (receiver samples on rising SCK):
- Command byte:
  - disable = 0x40;
  - enable = 0x41;
  - write = 0x20 | `cmd_line`.
- A write is followed by 256 payload bytes, for `data_addr` 0..255 in order.
- Reserved op 3: accepted (one-cycle handshake) and dropped. No SPI activity, no `data_req`.

Transaction sequencing:
- `cmd_op` and `cmd_line` are latched at acceptance. Later changes are ignored.
- `SPI_DI` changes only while `SPI_SCK` is low, or on the cycle SCK goes low.
- `SPI_SCK` is low whenever `SPI_SS3` is high.

State machine:
- IDLE: SS3=1, SCK=0, DI=0.
  - Accept write/enable/disable → SETUP, loading the command byte into the shift register.
- SETUP: SS3=0, SCK=0, DI=shift[7] for `CLK_DIV` cycles → HIGH.
- HIGH: SCK=1 for `CLK_DIV` cycles. Then:
  - if bit counter ≠ 7 → LOW, with shift left and bit counter +1;
  - else if write and bytes sent < 256 → FETCH;
  - else → TAIL.
- LOW: SCK=0, DI=shift[7] for `CLK_DIV` cycles → HIGH.
- FETCH: 2 cycles, SCK=0.
  - Cycle 0: `data_req`=1, `data_addr`=byte counter.
  - Cycle 1: shift register ← `data_in`, bit counter ← 0, byte counter +1.
  - Then → LOW.
- TAIL: SCK=0 for `CLK_DIV` cycles → GAP.
- GAP: SS3=1 for 2×`CLK_DIV` cycles → IDLE.

Counters:
- Divider counter: 8-bit.
- Bit counter: 3-bit.
- Byte counter: 9-bit. It counts 0..256 and never wraps within a transaction.

Reset:
- Reset values: `cmd_ready`=1, `busy`=0, `data_req`=0, `data_addr`=0, SCK=0, SS3=1, DI=0, state IDLE.
- Reset asserted mid-transaction aborts immediately, with SS3 forced high in the same instant. The receiver discards the partial byte.

## Timing
- Acceptance at edge N: SS3 falls and DI = bit 7 at edge N+1.
- First SCK rise at N+1+`CLK_DIV`.
- Each bit occupies 2×`CLK_DIV` cycles: `CLK_DIV` low, then `CLK_DIV` high.
- Enable/disable: SS3 is low for 16×`CLK_DIV` + `CLK_DIV` cycles, then high for the 2×`CLK_DIV` cycle gap. `cmd_ready` returns high at the end of the gap.
- Write: SS3 low time = 16×`CLK_DIV` + 256×(2 + 16×`CLK_DIV`) + `CLK_DIV` cycles.
- Exactly 8 rising SCK edges per byte, so 8 or 2056 per transaction.
- `cmd_valid` held high in IDLE → back-to-back transactions. The gap guarantees SS3 high for at least 2×`CLK_DIV` cycles between them.
- `data_req` is never asserted outside FETCH cycle 0. Its latency to capture is fixed at 1 cycle, so `data_in` has no ready/valid.

## Structure
- Package `osd_pkg` holds:
  - OSD command constants: `OSD_CMD_WRITE`=8'h20, `OSD_CMD_ENABLE`=8'h40;
  - op enum (`OSD_OP_DISABLE`, `OSD_OP_ENABLE`, `OSD_OP_WRITE`);
  - `OSD_LINE_BYTES`=256.
- One natural sub-module: `spi_bit_shifter`. It owns the divider, shift register, bit counter and SCK/DI generation, with a byte load/done handshake to the sequencing FSM.

## Test plan
- `CLK_DIV`=2, op=1: SS3 low 34 cycles; 8 SCK rises; sampled byte 0x41; `cmd_ready` high 4 cycles after SS3 rises.
- `CLK_DIV`=2, op=2, line=5, `data_in`=`data_addr`^8'hA5:
  - first byte sampled is 0x25;
  - 256 payload bytes match;
  - 256 `data_req` pulses with addresses 0..255;
  - SS3 low 8738 cycles.
- Bench OSD receiver model after line-7 write then enable:
  - `osd_buffer[1792..2047]` equals sent data;
  - `osd_enable`=1.
- `cmd_valid` held high with ops 1, 0, 1: three transactions; SS3 high ≥ 2×`CLK_DIV` between them; bytes 0x41, 0x40, 0x41.
- Op 3: one-cycle `cmd_ready` drop, then immediately ready; no SCK edge; SS3 stays high.
- `reset_n` pulsed low during payload byte 100: SS3=1, SCK=0, DI=0 asynchronously; `cmd_ready`=1 after release; the next enable transmits 0x41 cleanly.
